// File: rtl/next_state_selector.sv
// Microsequencer next-state selector: registers the microstore address each cycle.
// Optional call/return stack enabled by defining NSS_STACK_EN.
module next_state_selector #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_LIMIT  = 255,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        ns_sel,
    input  logic [1:0]        cond_sel,
    input  logic              inv,
    input  logic [ADDR_W-1:0] cr_addr,
    input  logic [ADDR_W-1:0] decode_addr,
    input  logic              moc,
    input  logic              cond_true,
    output logic [ADDR_W-1:0] next_state,
    output logic              wait_timeout,
    output logic              stack_ovf,
    output logic              stack_unf
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    localparam logic [2:0] NS_DECODE = 3'b000;
    localparam logic [2:0] NS_FETCH  = 3'b001;
    localparam logic [2:0] NS_JUMP   = 3'b010;
    localparam logic [2:0] NS_INC    = 3'b011;
    localparam logic [2:0] NS_BRANCH = 3'b100;
    localparam logic [2:0] NS_WAIT   = 3'b101;
    localparam logic [2:0] NS_CALL   = 3'b110;
    localparam logic [2:0] NS_RET    = 3'b111;

    logic [ADDR_W-1:0] next_state_r;
    logic [ADDR_W-1:0] inc_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              wait_timeout_r;

    logic              sel_cond_s;
    logic              c_s;
    logic [ADDR_W-1:0] d_s;
    logic [CNT_W-1:0]  cnt_d_s;
    logic              timeout_set_s;

`ifdef NSS_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] stack_r [STACK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic [SP_W-1:0]   sp_m1_s;
    logic [IDX_W-1:0]  push_idx_s;
    logic [IDX_W-1:0]  pop_idx_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              stack_ovf_r;
    logic              stack_unf_r;

    assign sp_m1_s    = sp_r - SP_W'(1);
    assign push_idx_s = sp_r[IDX_W-1:0];
    assign pop_idx_s  = sp_m1_s[IDX_W-1:0];
    assign full_s     = (sp_r == SP_W'(STACK_DEPTH));
    assign empty_s    = (sp_r == SP_W'(0));
`endif

    // Next-address selection, wait hold counting and stack request decode
    always_comb begin
        case (cond_sel)
            2'b00:   sel_cond_s = moc;
            2'b01:   sel_cond_s = cond_true;
            2'b10:   sel_cond_s = 1'b1;
            2'b11:   sel_cond_s = 1'b0;
            default: sel_cond_s = 1'b0;
        endcase
        c_s           = sel_cond_s ^ inv;
        d_s           = '0;
        cnt_d_s       = '0;
        timeout_set_s = 1'b0;
`ifdef NSS_STACK_EN
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
`endif
        case (ns_sel)
            NS_DECODE: d_s = decode_addr;
            NS_FETCH:  d_s = '0;
            NS_JUMP:   d_s = cr_addr;
            NS_INC:    d_s = inc_r;
            NS_BRANCH: d_s = c_s ? cr_addr : inc_r;
            NS_WAIT: begin
                if (c_s) begin
                    d_s = inc_r;
                end else if (wait_cnt_r == CNT_W'(WAIT_LIMIT - 1)) begin
                    // this hold would hit the limit: abort back to fetch
                    d_s           = '0;
                    timeout_set_s = 1'b1;
                end else begin
                    d_s     = next_state_r;
                    cnt_d_s = wait_cnt_r + CNT_W'(1);
                end
            end
            NS_CALL: begin
                d_s = cr_addr;
`ifdef NSS_STACK_EN
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
`endif
            end
            NS_RET: begin
`ifdef NSS_STACK_EN
                if (empty_s) begin
                    d_s       = '0;
                    unf_set_s = 1'b1;
                end else begin
                    d_s   = stack_r[pop_idx_s];
                    pop_s = 1'b1;
                end
`else
                d_s = '0;
`endif
            end
            default: d_s = '0;
        endcase
    end

    // Address, incrementer, wait counter and timeout flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_state_r   <= '0;
            inc_r          <= ADDR_W'(1);
            wait_cnt_r     <= '0;
            wait_timeout_r <= 1'b0;
        end else begin
            next_state_r   <= d_s;
            inc_r          <= d_s + ADDR_W'(1);
            wait_cnt_r     <= cnt_d_s;
            wait_timeout_r <= wait_timeout_r | timeout_set_s;
        end
    end

`ifdef NSS_STACK_EN
    // Return-address LIFO, pointer and sticky stack error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= '0;
            end
            sp_r        <= '0;
            stack_ovf_r <= 1'b0;
            stack_unf_r <= 1'b0;
        end else begin
            if (push_s) begin
                stack_r[push_idx_s] <= inc_r;
                sp_r                <= sp_r + SP_W'(1);
            end else if (pop_s) begin
                sp_r <= sp_m1_s;
            end else begin
                sp_r <= sp_r;
            end
            stack_ovf_r <= stack_ovf_r | ovf_set_s;
            stack_unf_r <= stack_unf_r | unf_set_s;
        end
    end

    assign stack_ovf = stack_ovf_r;
    assign stack_unf = stack_unf_r;
`else
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    assign next_state   = next_state_r;
    assign wait_timeout = wait_timeout_r;

endmodule

// File: tb/tb_next_state_selector.sv
// Bench for next_state_selector: directed vector table, hand-written reset/stack
// sequences, and randomized traffic checked against a behavioural model.
module tb_next_state_selector;

    localparam int AW = 10;
    localparam int WL = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    ns_sel;
    logic [1:0]    cond_sel;
    logic          inv;
    logic [AW-1:0] cr_addr;
    logic [AW-1:0] decode_addr;
    logic          moc;
    logic          cond_true;
    logic [AW-1:0] next_state;
    logic          wait_timeout;
    logic          stack_ovf;
    logic          stack_unf;

    int n_checks = 0;
    int n_fail   = 0;

    next_state_selector #(.ADDR_W(AW), .WAIT_LIMIT(WL), .STACK_DEPTH(SD)) dut (
        .clk(clk), .reset(reset), .ns_sel(ns_sel), .cond_sel(cond_sel), .inv(inv),
        .cr_addr(cr_addr), .decode_addr(decode_addr), .moc(moc), .cond_true(cond_true),
        .next_state(next_state), .wait_timeout(wait_timeout),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    s;
        logic [1:0]    cs;
        logic          iv;
        logic [AW-1:0] cr;
        logic [AW-1:0] dec;
        logic          m;
        logic          ct;
        logic [AW-1:0] exp_ns;
        logic          exp_to;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state
    int m_ns, m_inc, m_holds, m_to, m_ovf, m_unf;
    int m_stack[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] s, input logic [1:0] cs, input logic iv,
                          input logic [AW-1:0] cr, input logic [AW-1:0] dec,
                          input logic m, input logic ct);
        ns_sel = s; cond_sel = cs; inv = iv; cr_addr = cr;
        decode_addr = dec; moc = m; cond_true = ct;
    endtask

    task automatic step(input logic [2:0] s, input logic [1:0] cs, input logic iv,
                        input logic [AW-1:0] cr, input logic [AW-1:0] dec,
                        input logic m, input logic ct);
        set_in(s, cs, iv, cr, dec, m, ct);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ns = 0; m_inc = 1; m_holds = 0; m_to = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int c, d;
        int sel[4];
        sel[0] = int'(moc); sel[1] = int'(cond_true); sel[2] = 1; sel[3] = 0;
        c = sel[cond_sel] ^ int'(inv);
        d = 0;
        if (ns_sel != 3'd5) m_holds = 0;
        case (ns_sel)
            3'd0: d = int'(decode_addr);
            3'd1: d = 0;
            3'd2: d = int'(cr_addr);
            3'd3: d = m_inc;
            3'd4: d = (c != 0) ? int'(cr_addr) : m_inc;
            3'd5: begin
                if (c != 0) begin
                    d = m_inc; m_holds = 0;
                end else if (m_holds + 1 >= WL) begin
                    d = 0; m_to = 1; m_holds = 0;
                end else begin
                    d = m_ns; m_holds++;
                end
            end
            3'd6: begin
                d = int'(cr_addr);
`ifdef NSS_STACK_EN
                if (m_stack.size() < SD) m_stack.push_back(m_inc);
                else m_ovf = 1;
`endif
            end
            default: begin
`ifdef NSS_STACK_EN
                if (m_stack.size() > 0) d = m_stack.pop_back();
                else begin d = 0; m_unf = 1; end
`else
                d = 0;
`endif
            end
        endcase
        m_ns  = d;
        m_inc = (d + 1) % (1 << AW);
    endtask

    initial begin
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h001, 1'b0});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h002, 1'b0});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h003, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h003, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h003, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b1, 1'b0, 10'h004, 1'b0});
        vecs.push_back('{3'd4, 2'd1, 1'b1, 10'h0C8, 10'h000, 1'b0, 1'b1, 10'h005, 1'b0});
        vecs.push_back('{3'd4, 2'd1, 1'b0, 10'h0C8, 10'h000, 1'b0, 1'b1, 10'h0C8, 1'b0});
        vecs.push_back('{3'd0, 2'd0, 1'b0, 10'h000, 10'h2A5, 1'b0, 1'b0, 10'h2A5, 1'b0});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h2A6, 1'b0});
        vecs.push_back('{3'd2, 2'd0, 1'b0, 10'h3FF, 10'h000, 1'b0, 1'b0, 10'h3FF, 1'b0});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0});
        vecs.push_back('{3'd2, 2'd0, 1'b0, 10'h155, 10'h000, 1'b0, 1'b0, 10'h155, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h155, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h155, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h155, 1'b0});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h001, 1'b1});
        vecs.push_back('{3'd5, 2'd3, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 10'h001, 1'b1});
        vecs.push_back('{3'd5, 2'd3, 1'b0, 10'h000, 10'h000, 1'b1, 1'b1, 10'h001, 1'b1});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 10'h002, 1'b1});
        vecs.push_back('{3'd5, 2'd2, 1'b1, 10'h000, 10'h000, 1'b0, 1'b0, 10'h002, 1'b1});
        vecs.push_back('{3'd5, 2'd2, 1'b1, 10'h000, 10'h000, 1'b0, 1'b0, 10'h002, 1'b1});
        vecs.push_back('{3'd5, 2'd2, 1'b1, 10'h000, 10'h000, 1'b0, 1'b0, 10'h002, 1'b1});
        vecs.push_back('{3'd5, 2'd2, 1'b1, 10'h000, 10'h000, 1'b0, 1'b0, 10'h000, 1'b1});

        reset = 1'b1;
        set_in(3'd0, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        #12;
        chk("reset next_state", 32'(next_state), 32'h0);
        chk("reset wait_timeout", 32'(wait_timeout), 32'h0);
        chk("reset stack_ovf", 32'(stack_ovf), 32'h0);
        chk("reset stack_unf", 32'(stack_unf), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].cs, vecs[i].iv, vecs[i].cr, vecs[i].dec, vecs[i].m, vecs[i].ct);
            chk($sformatf("vec%0d next_state", i), 32'(next_state), 32'(vecs[i].exp_ns));
            chk($sformatf("vec%0d wait_timeout", i), 32'(wait_timeout), 32'(vecs[i].exp_to));
        end

        // asynchronous reset in the middle of a WAIT hold
        step(3'd2, 2'd0, 1'b0, 10'h077, '0, 1'b0, 1'b0);
        step(3'd5, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("mid-wait hold", 32'(next_state), 32'h077);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset next_state", 32'(next_state), 32'h0);
        chk("async reset wait_timeout", 32'(wait_timeout), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(3'd3, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("post-reset inc1", 32'(next_state), 32'h1);
        step(3'd3, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("post-reset inc2", 32'(next_state), 32'h2);
        step(3'd3, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("post-reset inc3", 32'(next_state), 32'h3);

        step(3'd2, 2'd0, 1'b0, 10'h020, '0, 1'b0, 1'b0);
        step(3'd6, 2'd0, 1'b0, 10'h100, '0, 1'b0, 1'b0);
        chk("call target", 32'(next_state), 32'h100);
`ifdef NSS_STACK_EN
        step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("ret address", 32'(next_state), 32'h021);
        step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("ret empty next_state", 32'(next_state), 32'h0);
        chk("ret empty stack_unf", 32'(stack_unf), 32'h1);
        chk("ret empty stack_ovf", 32'(stack_ovf), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            step(3'd6, 2'd0, 1'b0, AW'(k * 32'h40), '0, 1'b0, 1'b0);
            chk($sformatf("call%0d target", k), 32'(next_state), 32'(k * 32'h40));
            chk($sformatf("call%0d stack_ovf", k), 32'(stack_ovf), (k == 5) ? 32'h1 : 32'h0);
        end
        for (int k = 4; k >= 1; k--) begin
            step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
            chk($sformatf("unwind ret%0d", k), 32'(next_state), 32'((k - 1) * 32'h40 + 1));
        end
        step(3'd6, 2'd0, 1'b0, 10'h200, '0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("reset mid-sub stack_ovf", 32'(stack_ovf), 32'h0);
        chk("reset mid-sub stack_unf", 32'(stack_unf), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("ret after reset", 32'(next_state), 32'h0);
        chk("ret after reset stack_unf", 32'(stack_unf), 32'h1);
`else
        step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("nostack ret", 32'(next_state), 32'h0);
        for (int k = 0; k < 6; k++) begin
            step(3'd6, 2'd0, 1'b0, AW'(10'h300 + k), '0, 1'b0, 1'b0);
        end
        chk("nostack call jump", 32'(next_state), 32'h305);
        step(3'd7, 2'd0, 1'b0, '0, '0, 1'b0, 1'b0);
        chk("nostack ret fetch", 32'(next_state), 32'h0);
        chk("nostack stack_ovf", 32'(stack_ovf), 32'h0);
        chk("nostack stack_unf", 32'(stack_unf), 32'h0);
`endif

        // randomized traffic against the behavioural model
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] s;
            s = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) s = 3'd5;
            set_in(s, 2'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                   ($urandom_range(0, 3) == 0), 1'($urandom));
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rand%0d next_state", n), 32'(next_state), 32'(m_ns));
            chk($sformatf("rand%0d wait_timeout", n), 32'(wait_timeout), 32'(m_to));
            chk($sformatf("rand%0d stack_ovf", n), 32'(stack_ovf), 32'(m_ovf));
            chk($sformatf("rand%0d stack_unf", n), 32'(stack_unf), 32'(m_unf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
